// File: rtl/arbitrary_sequence_checker.sv
// ---------------------------------------------------------------------------
// arbitrary_sequence_checker
//
// Receive-side checker for the repeating 7-step code sequence
// 0,1,2,3,6,5,7 produced by the arbitrary counter. Each sampled code is
// decoded back to its sequence index (0..6). The checker hunts for a run of
// LOCK_COUNT consecutive correct transitions, then locks. While locked it
// flags out-of-order codes (seq_error). It flags the one unused code, 3'b100,
// in any state (illegal_code). A saturating counter accumulates both kinds
// of error.
//
// Parameters
//   LOCK_COUNT   consecutive correct transitions needed to lock (1..15)
//   ERR_WIDTH    width of err_count
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high; clears all state and outputs
//   in_valid      in_code is sampled on this edge when high
//   in_code       received 3-bit code
//   clear_errors  synchronous clear of err_count
//   index         decoded index of the last legal sample
//   index_valid   pulse: legal, in-order sample accepted while locked
//   locked        high while in the LOCKED state
//   wrap          pulse: in-order index 6 accepted while locked
//   seq_error     pulse: legal but out-of-order sample while locked
//   illegal_code  pulse: code 3'b100 sampled (any state)
//   err_count     saturating count of seq_error + illegal_code events
//
// All outputs are registered and appear one cycle after the sampling edge.
// ---------------------------------------------------------------------------
module arbitrary_sequence_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2:0]           in_code,
    input  logic                 clear_errors,
    output logic [2:0]           index,
    output logic                 index_valid,
    output logic                 locked,
    output logic                 wrap,
    output logic                 seq_error,
    output logic                 illegal_code,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [4:0]           LOCK_TARGET = 5'(LOCK_COUNT);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX     = '1;

    // Registered state
    state_t         state;
    logic [2:0]     prev_idx;
    logic           have_prev;
    logic [3:0]     run_cnt;

    // Next-state values
    state_t         state_nx;
    logic [2:0]     prev_idx_nx;
    logic           have_prev_nx;
    logic [3:0]     run_cnt_nx;
    logic [2:0]     index_nx;
    logic           index_valid_nx;
    logic           wrap_nx;
    logic           seq_error_nx;
    logic           illegal_code_nx;
    logic [ERR_WIDTH-1:0] err_count_nx;

    // Decode
    logic           code_legal;
    logic [2:0]     code_idx;
    logic [2:0]     expected_idx;
    logic           is_match;
    logic           err_event;

    // NOTE: every signal driven in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        code_legal = 1'b1;
        code_idx   = 3'd0;
        case (in_code)
            3'd0:    code_idx = 3'd0;
            3'd1:    code_idx = 3'd1;
            3'd2:    code_idx = 3'd2;
            3'd3:    code_idx = 3'd3;
            3'd6:    code_idx = 3'd4;
            3'd5:    code_idx = 3'd5;
            3'd7:    code_idx = 3'd6;
            default: code_legal = 1'b0;   // 3'b100 never appears in the sequence
        endcase
    end

    // Index 6 is the last step; the sequence wraps back to index 0.
    assign expected_idx = (prev_idx == 3'd6) ? 3'd0 : prev_idx + 3'd1;
    assign is_match     = have_prev && (code_idx == expected_idx);

    // Next-state and output logic
    always_comb begin
        state_nx        = state;
        prev_idx_nx     = prev_idx;
        have_prev_nx    = have_prev;
        run_cnt_nx      = run_cnt;
        index_nx        = index;
        index_valid_nx  = 1'b0;
        wrap_nx         = 1'b0;
        seq_error_nx    = 1'b0;
        illegal_code_nx = 1'b0;
        err_event       = 1'b0;

        if (in_valid) begin
            if (!code_legal) begin
                // Illegal code: drop lock and forget history; index holds.
                illegal_code_nx = 1'b1;
                err_event       = 1'b1;
                state_nx        = HUNT;
                have_prev_nx    = 1'b0;
                run_cnt_nx      = 4'd0;
            end else begin
                prev_idx_nx  = code_idx;
                have_prev_nx = 1'b1;
                index_nx     = code_idx;
                case (state)
                    HUNT: begin
                        if (is_match) begin
                            run_cnt_nx = run_cnt + 4'd1;
                            if ((5'(run_cnt) + 5'd1) >= LOCK_TARGET)
                                state_nx = LOCKED;
                        end else begin
                            run_cnt_nx = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_match) begin
                            index_valid_nx = 1'b1;
                            wrap_nx        = (code_idx == 3'd6);
                        end else begin
                            // Offending sample becomes the start of a new run.
                            seq_error_nx = 1'b1;
                            err_event    = 1'b1;
                            state_nx     = HUNT;
                            run_cnt_nx   = 4'd0;
                        end
                    end
                    default: state_nx = HUNT;
                endcase
            end
        end

        // A clear coincident with an event still records that event.
        if (clear_errors)
            err_count_nx = err_event ? ERR_WIDTH'(1) : '0;
        else if (err_event && (err_count != ERR_MAX))
            err_count_nx = err_count + ERR_WIDTH'(1);
        else
            err_count_nx = err_count;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= HUNT;
            prev_idx     <= 3'd0;
            have_prev    <= 1'b0;
            run_cnt      <= 4'd0;
            index        <= 3'd0;
            index_valid  <= 1'b0;
            wrap         <= 1'b0;
            seq_error    <= 1'b0;
            illegal_code <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_nx;
            prev_idx     <= prev_idx_nx;
            have_prev    <= have_prev_nx;
            run_cnt      <= run_cnt_nx;
            index        <= index_nx;
            index_valid  <= index_valid_nx;
            wrap         <= wrap_nx;
            seq_error    <= seq_error_nx;
            illegal_code <= illegal_code_nx;
            err_count    <= err_count_nx;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_arbitrary_sequence_checker.sv
// ---------------------------------------------------------------------------
// tb_arbitrary_sequence_checker
//
// Directed bench for arbitrary_sequence_checker. The main instance uses
// LOCK_COUNT=3, ERR_WIDTH=8; a second instance with ERR_WIDTH=2 exercises
// err_count saturation and clearing. Inputs change on the falling edge and
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_arbitrary_sequence_checker;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Main instance
    logic       in_valid, clear_errors;
    logic [2:0] in_code;
    logic [2:0] index;
    logic       index_valid, locked, wrap, seq_error, illegal_code;
    logic [7:0] err_count;

    // Saturation instance
    logic       s_valid, s_clear;
    logic [2:0] s_code;
    logic [2:0] s_index;
    logic       s_index_valid, s_locked, s_wrap, s_seq_error, s_illegal_code;
    logic [1:0] s_err_count;

    int checks = 0;
    int fails  = 0;

    arbitrary_sequence_checker #(.LOCK_COUNT(3), .ERR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_code(in_code),
        .clear_errors(clear_errors), .index(index), .index_valid(index_valid),
        .locked(locked), .wrap(wrap), .seq_error(seq_error),
        .illegal_code(illegal_code), .err_count(err_count)
    );

    arbitrary_sequence_checker #(.LOCK_COUNT(3), .ERR_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(s_valid), .in_code(s_code),
        .clear_errors(s_clear), .index(s_index), .index_valid(s_index_valid),
        .locked(s_locked), .wrap(s_wrap), .seq_error(s_seq_error),
        .illegal_code(s_illegal_code), .err_count(s_err_count)
    );

    // One valid sample on the main instance; returns 1 unit after the edge.
    task automatic send(input logic [2:0] code);
        @(negedge clock);
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic s_cycle(input logic v, input logic [2:0] code, input logic clr);
        @(negedge clock);
        s_valid = v;
        s_code  = code;
        s_clear = clr;
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] seq [4];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3};
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if ({index, index_valid, locked, wrap, seq_error, illegal_code, err_count} !== 16'h0) begin
            fails++; $display("FAIL reset_initial outputs got %h exp 0",
                              {index, index_valid, locked, wrap, seq_error, illegal_code, err_count});
        end
        @(negedge clock);
        reset = 1'b0;

        // Build up err_count=5 and lock, then reset asynchronously.
        repeat (5) send(3'd4);
        for (int i = 0; i < 4; i++) send(seq[i]);
        checks++; if (locked !== 1'b1 || err_count !== 8'd5) begin
            fails++; $display("FAIL reset_prelock locked/err got %b/%0d exp 1/5", locked, err_count);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({index, index_valid, locked, wrap, seq_error, illegal_code, err_count} !== 16'h0) begin
            fails++; $display("FAIL reset_async outputs got %h exp 0",
                              {index, index_valid, locked, wrap, seq_error, illegal_code, err_count});
        end
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) send(seq[i]);
        checks++; if (locked !== 1'b0) begin
            fails++; $display("FAIL reset_relock_early locked got %b exp 0", locked);
        end
        send(3'd3);
        checks++; if (locked !== 1'b1 || index !== 3'd3 || index_valid !== 1'b0) begin
            fails++; $display("FAIL reset_relock locked/index/iv got %b/%0d/%b exp 1/3/0",
                              locked, index, index_valid);
        end
    endtask

    task automatic test_lock_with_gaps();
        pulse_reset();
        send(3'd3);
        checks++; if (index_valid !== 1'b0 || locked !== 1'b0 || index !== 3'd3) begin
            fails++; $display("FAIL gaps_first iv/locked/index got %b/%b/%0d exp 0/0/3",
                              index_valid, locked, index);
        end
        idle(); idle();
        send(3'd6);
        checks++; if (index_valid !== 1'b0 || locked !== 1'b0 || index !== 3'd4) begin
            fails++; $display("FAIL gaps_6 iv/locked/index got %b/%b/%0d exp 0/0/4",
                              index_valid, locked, index);
        end
        idle();
        send(3'd5);
        checks++; if (index_valid !== 1'b0 || locked !== 1'b0) begin
            fails++; $display("FAIL gaps_5 iv/locked got %b/%b exp 0/0", index_valid, locked);
        end
        send(3'd7);
        checks++; if (locked !== 1'b1 || index_valid !== 1'b0 || wrap !== 1'b0 || index !== 3'd6) begin
            fails++; $display("FAIL gaps_lock locked/iv/wrap/index got %b/%b/%b/%0d exp 1/0/0/6",
                              locked, index_valid, wrap, index);
        end
        checks++; if (err_count !== 8'd0) begin
            fails++; $display("FAIL gaps_err err_count got %0d exp 0", err_count);
        end
    endtask

    // Locked with previous index 6: full cycle back-to-back across the wrap.
    task automatic test_wrap();
        logic [2:0] codes [9];
        logic [2:0] exp_idx [9];
        logic       exp_wrap [9];
        codes    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1};
        exp_idx  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            send(codes[i]);
            checks++; if (index !== exp_idx[i] || index_valid !== 1'b1 || wrap !== exp_wrap[i]
                          || locked !== 1'b1 || seq_error !== 1'b0) begin
                fails++; $display("FAIL wrap[%0d] index/iv/wrap/locked/serr got %0d/%b/%b/%b/%b exp %0d/1/%b/1/0",
                                  i, index, index_valid, wrap, locked, seq_error, exp_idx[i], exp_wrap[i]);
            end
        end
    endtask

    // Locked after ...,0,1; advance to index 3 so index 4 (code 6) is expected.
    task automatic test_mismatch_relock();
        send(3'd2);
        send(3'd3);
        send(3'd5);
        checks++; if (seq_error !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || index_valid !== 1'b0) begin
            fails++; $display("FAIL mismatch serr/locked/err/iv got %b/%b/%0d/%b exp 1/0/1/0",
                              seq_error, locked, err_count, index_valid);
        end
        send(3'd7);
        checks++; if (seq_error !== 1'b0 || locked !== 1'b0) begin
            fails++; $display("FAIL mismatch_7 serr/locked got %b/%b exp 0/0", seq_error, locked);
        end
        send(3'd0);
        checks++; if (locked !== 1'b0) begin
            fails++; $display("FAIL mismatch_0 locked got %b exp 0", locked);
        end
        send(3'd1);
        checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin
            fails++; $display("FAIL mismatch_relock locked/err got %b/%0d exp 1/1", locked, err_count);
        end
    endtask

    // Locked with index 1.
    task automatic test_illegal();
        send(3'd4);
        checks++; if (illegal_code !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2
                      || index !== 3'd1 || seq_error !== 1'b0) begin
            fails++; $display("FAIL illegal ill/locked/err/index/serr got %b/%b/%0d/%0d/%b exp 1/0/2/1/0",
                              illegal_code, locked, err_count, index, seq_error);
        end
        send(3'd0);
        checks++; if (illegal_code !== 1'b0 || locked !== 1'b0 || index !== 3'd0) begin
            fails++; $display("FAIL illegal_next ill/locked/index got %b/%b/%0d exp 0/0/0",
                              illegal_code, locked, index);
        end
        send(3'd1);
        send(3'd2);
        checks++; if (locked !== 1'b0) begin
            fails++; $display("FAIL illegal_early locked got %b exp 0", locked);
        end
        send(3'd3);
        checks++; if (locked !== 1'b1 || err_count !== 8'd2) begin
            fails++; $display("FAIL illegal_relock locked/err got %b/%0d exp 1/2", locked, err_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_err [5];
        exp_err = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            s_cycle(1'b1, 3'd4, 1'b0);
            checks++; if (s_err_count !== exp_err[i] || s_illegal_code !== 1'b1) begin
                fails++; $display("FAIL sat[%0d] err/ill got %0d/%b exp %0d/1",
                                  i, s_err_count, s_illegal_code, exp_err[i]);
            end
        end
        s_cycle(1'b1, 3'd4, 1'b1);
        checks++; if (s_err_count !== 2'd1) begin
            fails++; $display("FAIL sat_clear_event err got %0d exp 1", s_err_count);
        end
        s_cycle(1'b0, 3'd0, 1'b1);
        checks++; if (s_err_count !== 2'd0 || s_illegal_code !== 1'b0) begin
            fails++; $display("FAIL sat_clear err/ill got %0d/%b exp 0/0", s_err_count, s_illegal_code);
        end
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_code      = 3'd0;
        clear_errors = 1'b0;
        s_valid      = 1'b0;
        s_code       = 3'd0;
        s_clear      = 1'b0;

        test_reset();
        test_lock_with_gaps();
        test_wrap();
        test_mismatch_relock();
        test_illegal();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
